// File: rtl/clk_div_bank.sv
// Bank of NCH programmable tick / square-wave generators on clk_100M with glitch-free divisor reload.
// Optional DIV_SYNC_EN adds a 'sync' input that restarts every channel phase-aligned.
module clk_div_bank #(
  parameter int NCH       = 4,
  parameter int CW        = 32,
  parameter int DIV_RESET = 400000,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_100M,
  input  logic             rst_n,
  input  logic             div_wr,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [CW-1:0]    div_data,
  input  logic [NCH-1:0]   ch_en,
`ifdef DIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             div_ack,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  localparam logic [CW-1:0] DIV_INIT = CW'(DIV_RESET);

  logic [31:0] sel_ext;
  logic        sync_now;

  assign sel_ext = {{(32-SEL_W){1'b0}}, div_sel};

`ifdef DIV_SYNC_EN
  assign sync_now = sync;
`else
  assign sync_now = 1'b0;
`endif

  // Out-of-range selects are silently dropped and produce no acknowledge.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      div_ack <= 1'b0;
    end else begin
      div_ack <= div_wr && (sel_ext < 32'(NCH));
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic [CW-1:0] shadow;
    logic [CW-1:0] active;
    logic [CW-1:0] limit;
    logic          wr_hit;
    logic          tick_q;
    logic          sq_q;

    // A divisor of zero behaves like one, so the limit saturates at zero.
    assign limit  = (active == '0) ? '0 : active - CW'(1);
    assign wr_hit = div_wr && (sel_ext == 32'(i));

    // active only reloads at a period boundary, so a same-cycle write lands one period later.
    always_ff @(posedge clk_100M or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        shadow <= DIV_INIT;
        active <= DIV_INIT;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        if (wr_hit) begin
          shadow <= div_data;
        end
        if (sync_now || !ch_en[i]) begin
          cnt    <= '0;
          tick_q <= 1'b0;
          sq_q   <= 1'b0;
          active <= shadow;
        end else if (cnt == limit) begin
          cnt    <= '0;
          tick_q <= 1'b1;
          sq_q   <= ~sq_q;
          active <= shadow;
        end else begin
          cnt    <= cnt + CW'(1);
          tick_q <= 1'b0;
        end
      end
    end

    assign tick[i] = tick_q;
    assign sq[i]   = sq_q;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomized bench for clk_div_bank: a 2-channel and a 3-channel instance (the latter exposes an
// out-of-range select) are checked every cycle against an edge-counting reference model.
module tb_clk_div_bank;

  logic       clk_100M = 1'b0;
  logic       rst_n    = 1'b0;
  logic       div_wr   = 1'b0;
  logic       div_sel2 = 1'b0;
  logic [1:0] div_sel3 = 2'd0;
  logic [7:0] div_data = 8'd0;
  logic [2:0] ch_en    = 3'd0;
  logic       sync     = 1'b0;

  logic       ack2, ack3;
  logic [1:0] tick2, sq2;
  logic [2:0] tick3, sq3;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: [instance][channel]; instance 0 has 2 channels, instance 1 has 3.
  int nch [2] = '{2, 3};
  int pos [2][3];
  int per [2][3];
  int pend[2][3];
  bit mtick[2][3];
  bit msq  [2][3];
  bit mack [2];

  always #5 clk_100M = ~clk_100M;

  clk_div_bank #(.NCH(2), .CW(8), .DIV_RESET(4)) u_dut2 (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .div_wr   (div_wr),
    .div_sel  (div_sel2),
    .div_data (div_data),
    .ch_en    (ch_en[1:0]),
`ifdef DIV_SYNC_EN
    .sync     (sync),
`endif
    .div_ack  (ack2),
    .tick     (tick2),
    .sq       (sq2)
  );

  clk_div_bank #(.NCH(3), .CW(8), .DIV_RESET(4)) u_dut3 (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .div_wr   (div_wr),
    .div_sel  (div_sel3),
    .div_data (div_data),
    .ch_en    (ch_en),
`ifdef DIV_SYNC_EN
    .sync     (sync),
`endif
    .div_ack  (ack3),
    .tick     (tick3),
    .sq       (sq3)
  );

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        pos[k][c]   = 0;
        per[k][c]   = 4;
        pend[k][c]  = 4;
        mtick[k][c] = 1'b0;
        msq[k][c]   = 1'b0;
      end
      mack[k] = 1'b0;
    end
  endtask

  // One enabled edge advances the period position; the period closes after 'per' edges.
  task automatic modelStep(input logic [2:0] en, input logic wr, input int sel, input int data,
                           input logic syn);
    int s;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < nch[k]; c++) begin
        if (syn || !en[c]) begin
          pos[k][c]   = 0;
          mtick[k][c] = 1'b0;
          msq[k][c]   = 1'b0;
          per[k][c]   = eff(pend[k][c]);
        end else begin
          pos[k][c]++;
          if (pos[k][c] == per[k][c]) begin
            pos[k][c]   = 0;
            mtick[k][c] = 1'b1;
            msq[k][c]   = !msq[k][c];
            per[k][c]   = eff(pend[k][c]);
          end else begin
            mtick[k][c] = 1'b0;
          end
        end
      end
      s = (k == 0) ? (sel % 2) : sel;
      if (wr && s < nch[k]) begin
        pend[k][s] = data;
        mack[k]    = 1'b1;
      end else begin
        mack[k] = 1'b0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("d2 ack", 32'(ack2), 32'(mack[0]));
    checkOutput("d3 ack", 32'(ack3), 32'(mack[1]));
    for (int c = 0; c < 2; c++) begin
      checkOutput($sformatf("d2 tick%0d", c), 32'(tick2[c]), 32'(mtick[0][c]));
      checkOutput($sformatf("d2 sq%0d", c), 32'(sq2[c]), 32'(msq[0][c]));
    end
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("d3 tick%0d", c), 32'(tick3[c]), 32'(mtick[1][c]));
      checkOutput($sformatf("d3 sq%0d", c), 32'(sq3[c]), 32'(msq[1][c]));
    end
  endtask

  task automatic applyStimulus(input logic [2:0] en, input logic wr, input logic [1:0] sel,
                               input logic [7:0] data, input logic syn);
    @(negedge clk_100M);
    ch_en    = en;
    div_wr   = wr;
    div_sel3 = sel;
    div_sel2 = sel[0];
    div_data = data;
    sync     = syn;
    @(posedge clk_100M);
    #1;
    modelStep(en, wr, int'(sel), int'(data), syn);
    compareAll();
  endtask

  // Assert reset away from the clock edge, check the asynchronous clear, then release quietly.
  task automatic pulseReset();
    @(posedge clk_100M);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    @(negedge clk_100M);
    rst_n    = 1'b1;
    ch_en    = 3'd0;
    div_wr   = 1'b0;
    sync     = 1'b0;
    @(posedge clk_100M);
    #1;
    modelStep(3'd0, 1'b0, 0, 0, 1'b0);
    compareAll();
  endtask

  initial begin
    logic [2:0] en;
    logic [7:0] d;
    logic       syn;
    bit         found;

    modelReset();
    #12;
    compareAll();
    @(negedge clk_100M);
    rst_n = 1'b1;

    // Channel 0 alone at the reset divisor.
    for (int n = 0; n < 14; n++) applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);

    // Divisor 1: continuous tick once it takes effect.
    applyStimulus(3'b001, 1'b1, 2'd0, 8'd1, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);

    // Back to 4, then a mid-period write of 6.
    applyStimulus(3'b001, 1'b1, 2'd0, 8'd4, 1'b0);
    for (int n = 0; n < 6; n++) applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);
    applyStimulus(3'b001, 1'b1, 2'd0, 8'd6, 1'b0);
    for (int n = 0; n < 14; n++) applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);

    // Write landing exactly on a wrap edge, located from the model with a bounded search.
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (pos[0][0] == per[0][0] - 1) found = 1'b1;
      else applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);
    end
    checkOutput("wrap located", 32'(found), 32'd1);
    applyStimulus(3'b001, 1'b1, 2'd0, 8'd3, 1'b0);
    for (int n = 0; n < 16; n++) applyStimulus(3'b001, 1'b0, 2'd0, 8'd0, 1'b0);

    // Out-of-range select on the 3-channel instance.
    applyStimulus(3'b111, 1'b1, 2'd3, 8'd2, 1'b0);
    for (int n = 0; n < 10; n++) applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);

    // Abort a period, re-enable a few cycles later, then reset mid-period.
    applyStimulus(3'b001, 1'b1, 2'd0, 8'd4, 1'b0);
    for (int n = 0; n < 7; n++) applyStimulus(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int n = 0; n < 3; n++) applyStimulus(3'b010, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int n = 0; n < 9; n++) applyStimulus(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    applyStimulus(3'b011, 1'b1, 2'd1, 8'd9, 1'b0);
    applyStimulus(3'b011, 1'b0, 2'd0, 8'd0, 1'b0);
    pulseReset();
    for (int n = 0; n < 10; n++) applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);

`ifdef DIV_SYNC_EN
    // Phase alignment: divisors 3 and 6 restarted together.
    applyStimulus(3'b111, 1'b1, 2'd0, 8'd3, 1'b0);
    applyStimulus(3'b111, 1'b1, 2'd1, 8'd6, 1'b0);
    for (int n = 0; n < 8; n++) applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
    applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b1);
    for (int n = 0; n < 5; n++) applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
    applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput("sync coincide", 32'({tick2[1], tick2[0]}), 32'd3);
    for (int n = 0; n < 12; n++) applyStimulus(3'b111, 1'b0, 2'd0, 8'd0, 1'b0);
`endif

    // Randomized traffic: mostly-enabled channels, frequent small divisor writes.
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) en[c] = ($urandom_range(7) != 0);
      d = ($urandom_range(15) == 0) ? 8'd0 : 8'($urandom_range(9, 1));
      syn = 1'b0;
`ifdef DIV_SYNC_EN
      syn = ($urandom_range(39) == 0);
`endif
      applyStimulus(en, ($urandom_range(3) == 0), 2'($urandom_range(3)), d, syn);
      if (n == 700) pulseReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
